alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: RV32-style ALU with valid/ready handshake and an iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter instead; then the SHIFT state is never entered.
module alu_multicycle #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [3:0]      ALUops,
    input  logic [XLEN-1:0] OP_A,
    input  logic [XLEN-1:0] OP_B,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT,
    output logic            BRANCH
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_XOR  = 4'd5,
        OP_OR   = 4'd6,
        OP_AND  = 4'd7,
        OP_SLT  = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BNE  = 4'd10,
        OP_BLT  = 4'd11,
        OP_BGE  = 4'd12,
        OP_BLTU = 4'd13,
        OP_BGEU = 4'd14,
        OP_SLTU = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    op_t             op;
    logic [4:0]      cnt;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic            go_shift;
    logic [XLEN-1:0] alu_res;
    logic            alu_br;

    assign shamt = OP_B[4:0];
    assign lt_s  = $signed(OP_A) < $signed(OP_B);
    assign lt_u  = OP_A < OP_B;

`ifdef ALU_FAST_SHIFT_EN
    assign go_shift = 1'b0;
`else
    assign go_shift = (ALUops == OP_SLL || ALUops == OP_SRL || ALUops == OP_SRA) && shamt != 5'd0;
`endif

    // Single-cycle result for everything except iterative shifts, which start from OP_A unshifted.
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (op_t'(ALUops))
            OP_ADD:  alu_res = OP_A + OP_B;
            OP_SUB:  alu_res = OP_A - OP_B;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res = OP_A << shamt;
            OP_SRL:  alu_res = OP_A >> shamt;
            OP_SRA:  alu_res = $signed(OP_A) >>> shamt;
`else
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = OP_A;
`endif
            OP_XOR:  alu_res = OP_A ^ OP_B;
            OP_OR:   alu_res = OP_A | OP_B;
            OP_AND:  alu_res = OP_A & OP_B;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_BEQ:  alu_br  = OP_A == OP_B;
            OP_BNE:  alu_br  = OP_A != OP_B;
            OP_BLT:  alu_br  = lt_s;
            OP_BGE:  alu_br  = !lt_s;
            OP_BLTU: alu_br  = lt_u;
            OP_BGEU: alu_br  = !lt_u;
        endcase
    end

    // Handshake FSM; RESULT doubles as the shift working register, so it only becomes visible in DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            op        <= OP_ADD;
            cnt       <= 5'd0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            BRANCH    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        op       <= op_t'(ALUops);
                        RESULT   <= alu_res;
                        BRANCH   <= alu_br;
                        IN_READY <= 1'b0;
                        if (go_shift) begin
                            cnt   <= shamt;
                            state <= SHIFT;
                        end else begin
                            OUT_VALID <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    RESULT <= op == OP_SLL ? RESULT << 1 :
                              op == OP_SRL ? RESULT >> 1 :
                                             {RESULT[XLEN-1], RESULT[XLEN-1:1]};
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    IN_READY <= 1'b1;
                end
            endcase
        end
    end
endmodule
